// File: rtl/sevseg_update_master.sv
// sevseg_update_master: Avalon-MM master that encodes a packed hex value and writes
// one seven-segment pattern per digit to consecutive PIO slave addresses.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start, value        one-cycle update request and packed hex digits (digit i = value[4i+3:4i])
//   busy, done          update in progress, one-cycle completion pulse
//   avm_*               Avalon-MM master (write path; read path only with readback)
//   verify_err          sticky readback mismatch flag
// Optional feature: define SEVSEG_READBACK_VERIFY_EN to read back and check every written digit.
module sevseg_update_master #(
    parameter int          NUM_DIGITS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_STRIDE = 16,
    parameter bit          ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    output logic [3:0]              avm_byteenable,
    input  logic                    avm_waitrequest,
    output logic                    avm_read,
    input  logic [31:0]             avm_readdata,
    output logic                    verify_err
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEVSEG_READBACK_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, NEXT, DONE, READ} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, NEXT, DONE} state_t;
`endif
    state_t                  state, state_d;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [3:0]              nib;
    logic [6:0]              pat;
    logic [31:0]             addr;
    logic                    last;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return ACTIVE_LOW ? ~p : p;
    endfunction

    // A shift avoids index-width mismatches for every legal NUM_DIGITS.
    assign nib  = 4'(value_q >> {idx, 2'b00});
    assign pat  = seg(nib);
    assign addr = BASE_ADDR + 32'(idx) * 32'(ADDR_STRIDE);
    assign last = idx == IW'(NUM_DIGITS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            value_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                value_q <= value;
                idx     <= '0;
            end else if (state == NEXT && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state;
        busy           = state != IDLE;
        done           = state == DONE;
        avm_write      = state == WRITE;
        avm_read       = 1'b0;
        avm_byteenable = 4'b1111;
`ifdef SEVSEG_READBACK_VERIFY_EN
        avm_read = state == READ;
`endif
        avm_address   = (avm_write || avm_read) ? addr : 32'h0;
        avm_writedata = avm_write ? {25'b0, pat} : 32'h0;
        case (state)
            IDLE:    state_d = start ? WRITE : IDLE;
`ifdef SEVSEG_READBACK_VERIFY_EN
            WRITE:   state_d = avm_waitrequest ? WRITE : READ;
            READ:    state_d = avm_waitrequest ? READ : NEXT;
`else
            WRITE:   state_d = avm_waitrequest ? WRITE : NEXT;
`endif
            NEXT:    state_d = last ? DONE : WRITE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SEVSEG_READBACK_VERIFY_EN
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:7];

    // Cleared by an accepted start so each update reports only its own mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            verify_err <= 1'b0;
        else if (state == IDLE && start)
            verify_err <= 1'b0;
        else if (state == READ && !avm_waitrequest && avm_readdata[6:0] != pat)
            verify_err <= 1'b1;
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
    assign verify_err      = 1'b0;
`endif
endmodule
